// File: rtl/pixclk_enable_gen.sv
// Fractional clock-enable generator: NUM_CH phase accumulators on refclk with a settle/lock sequencer.
// Optional per-channel strobe counters are built when PIXCLK_STROBE_COUNT_EN is defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SETTLE | counting LOCK_CYCLES after reset/retune; accumulators held at 0, clken low
//   ST_LOCKED | accumulators running, clken carries out, locked high
module pixclk_enable_gen #(
   parameter int          NUM_CH      = 1,
   parameter int          ACC_W       = 32,
   parameter int          LOCK_CYCLES = 1024,
   parameter logic [63:0] DEFAULT_INC = 64'd2162571352
) (
   input  logic                            refclk,
   input  logic                            rst_n,
   input  logic                            inc_wr,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] inc_ch,
   input  logic [ACC_W-1:0]                inc_data,
   output logic [NUM_CH-1:0]               clken,
   output logic                            locked,
   output logic [16*NUM_CH-1:0]            strobe_cnt
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(LOCK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
   localparam logic [ACC_W-1:0] DEF_INC  = ACC_W'(DEFAULT_INC);

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic                          locked_q, locked_d;
   logic [NUM_CH-1:0]             clken_q, clken_d;
   logic [NUM_CH-1:0][ACC_W-1:0]  acc_q, acc_d;
   logic [NUM_CH-1:0][ACC_W-1:0]  inc_q, inc_d;
   logic [NUM_CH-1:0][ACC_W:0]    sum;
   logic                          retune;

   // Writes to channels that do not exist are dropped without disturbing lock.
   assign retune = inc_wr && ({1'b0, inc_ch} < NUM_CH_L);

   always_comb begin
      sum = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      locked_d = locked_q;
      clken_d  = '0;
      acc_d    = acc_q;
      inc_d    = inc_q;
      if (retune) begin
         inc_d[inc_ch] = inc_data;
         acc_d         = '0;
         cnt_d         = '0;
         locked_d      = 1'b0;
         state_d       = ST_SETTLE;
      end else begin
         case (state_q)
            ST_SETTLE: begin
               acc_d = '0;
               if (cnt_q == CNT_LAST) begin
                  cnt_d    = '0;
                  locked_d = 1'b1;
                  state_d  = ST_LOCKED;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_LOCKED: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  acc_d[i]   = sum[i][ACC_W-1:0];
                  clken_d[i] = sum[i][ACC_W];
               end
            end
            default: begin
               state_d = ST_SETTLE;
            end
         endcase
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_SETTLE;
         cnt_q    <= '0;
         locked_q <= 1'b0;
         clken_q  <= '0;
         acc_q    <= '0;
         inc_q    <= {NUM_CH{DEF_INC}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
         clken_q  <= clken_d;
         acc_q    <= acc_d;
         inc_q    <= inc_d;
      end
   end

   assign clken  = clken_q;
   assign locked = locked_q;

`ifdef PIXCLK_STROBE_COUNT_EN
   logic [NUM_CH-1:0][15:0] scnt_q, scnt_d;

   // Counts advance on the same edge that raises clken, so the value includes that strobe.
   always_comb begin
      scnt_d = scnt_q;
      if (retune) begin
         scnt_d = '0;
      end else if (state_q == ST_LOCKED) begin
         for (int i = 0; i < NUM_CH; i++) begin
            scnt_d[i] = scnt_q[i] + 16'(sum[i][ACC_W]);
         end
      end
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         scnt_q <= '0;
      end else begin
         scnt_q <= scnt_d;
      end
   end

   assign strobe_cnt = scnt_q;
`else
   assign strobe_cnt = '0;
`endif

endmodule

// File: tb/tb_pixclk_enable_gen.sv
// Bench for pixclk_enable_gen: two-channel instance plus a three-channel instance for out-of-range writes.
module tb_pixclk_enable_gen;

   logic        refclk = 1'b0;
   logic        rst_n  = 1'b0;
   logic        inc_wr = 1'b0;
   logic [0:0]  inc_ch = '0;
   logic [31:0] inc_data = '0;
   logic [1:0]  clken;
   logic        locked;
   logic [31:0] strobe_cnt;

   logic        inc_wr3 = 1'b0;
   logic [1:0]  inc_ch3 = '0;
   logic [31:0] inc_data3 = '0;
   logic [2:0]  clken3;
   logic        locked3;
   logic [47:0] strobe_cnt3;

   int checks = 0;
   int errors = 0;

   always #5 refclk = ~refclk;

   pixclk_enable_gen #(.NUM_CH(2), .ACC_W(32), .LOCK_CYCLES(16)) dut (
      .refclk(refclk), .rst_n(rst_n), .inc_wr(inc_wr), .inc_ch(inc_ch),
      .inc_data(inc_data), .clken(clken), .locked(locked), .strobe_cnt(strobe_cnt)
   );

   pixclk_enable_gen #(.NUM_CH(3), .ACC_W(32), .LOCK_CYCLES(4)) dut3 (
      .refclk(refclk), .rst_n(rst_n), .inc_wr(inc_wr3), .inc_ch(inc_ch3),
      .inc_data(inc_data3), .clken(clken3), .locked(locked3), .strobe_cnt(strobe_cnt3)
   );

   typedef struct {
      logic        ch;
      logic [31:0] inc;
      int          ncyc;
      int          exp0;
      int          exp1;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   task automatic wr(input logic ch, input logic [31:0] d);
      inc_wr   = 1'b1;
      inc_ch   = ch;
      inc_data = d;
      step();
      inc_wr   = 1'b0;
   endtask

   task automatic wait_lock(output int n, output int bad);
      n   = 0;
      bad = 0;
      while (!locked && n < 200) begin
         step();
         n++;
         if (!locked && clken != 2'b00) bad++;
      end
   endtask

   task automatic count_strobes(input int ncyc, output int c0, output int c1);
      c0 = 0;
      c1 = 0;
      repeat (ncyc) begin
         step();
         c0 += int'(clken[0]);
         c1 += int'(clken[1]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n, bad, c0, c1, drops, waited;
      logic [1:0] e;

      tbl[0] = '{1'b0, 32'h6000_0000,   64,  24, 16};
      tbl[1] = '{1'b1, 32'hFFFF_FFFF,   64,  24, 63};
      tbl[2] = '{1'b0, 32'h0000_0000,   64,   0, 63};
      tbl[3] = '{1'b0, 32'h1000_0000,   64,   4, 63};
      tbl[4] = '{1'b1, 32'h0000_0001,   64,   4,  0};
      tbl[5] = '{1'b1, 32'h0000_0001,   64,   4,  0};
      tbl[6] = '{1'b0, 32'h8000_0000,  200, 100,  0};
      tbl[7] = '{1'b0, 32'h0000_0000,   64,   0,  0};
      tbl[8] = '{1'b1, 32'h0000_0000, 1000,   0,  0};

      #12;
      chk("rst_locked", locked, 0);
      chk("rst_clken", clken, 0);
      chk("rst_strobe_cnt", strobe_cnt, 0);
      @(posedge refclk);
      #1;
      rst_n = 1'b1;
      wait_lock(n, bad);
      chk("reset_settle_len", n, 16);
      chk("reset_settle_clken", bad, 0);

      // Out-of-range channel on the three-channel instance must not disturb lock.
      chk("ch3_locked_before", locked3, 1);
      inc_wr3 = 1'b1; inc_ch3 = 2'd3; inc_data3 = 32'h8000_0000;
      step();
      inc_wr3 = 1'b0;
      drops = 0;
      repeat (20) begin
         if (!locked3) drops++;
         step();
      end
      chk("ch3_ignored", drops, 0);
      inc_wr3 = 1'b1; inc_ch3 = 2'd2;
      step();
      inc_wr3 = 1'b0;
      chk("ch2_retune_unlock", locked3, 0);

      // Half-rate channel 0: first strobe on the 2nd LOCKED cycle.
      wr(1'b0, 32'h8000_0000);
      chk("wr0_unlock", locked, 0);
      wait_lock(n, bad);
      chk("wr0_settle_len", n, 16);
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("half_rate_k%0d", k), clken[0], (k % 2 == 0));
      end

      // Retune channel 1 while locked; both channels restart phase-aligned.
      wr(1'b1, 32'h4000_0000);
      chk("wr1_unlock", locked, 0);
      chk("wr1_clken", clken, 0);
      wait_lock(n, bad);
      chk("wr1_settle_len", n, 16);
      chk("wr1_settle_clken", bad, 0);
      for (int k = 1; k <= 16; k++) begin
         step();
         e = {(k % 4 == 0), (k % 2 == 0)};
         chk($sformatf("aligned_k%0d", k), clken, e);
      end

      for (int i = 0; i < 9; i++) begin
         wr(tbl[i].ch, tbl[i].inc);
         chk($sformatf("v%0d_unlock", i), locked, 0);
         chk($sformatf("v%0d_cnt_clear", i), strobe_cnt, 0);
         wait_lock(n, bad);
         chk($sformatf("v%0d_settle_len", i), n, 16);
         chk($sformatf("v%0d_settle_clken", i), bad, 0);
         count_strobes(tbl[i].ncyc, c0, c1);
         chk($sformatf("v%0d_count0", i), c0, tbl[i].exp0);
         chk($sformatf("v%0d_count1", i), c1, tbl[i].exp1);
`ifdef PIXCLK_STROBE_COUNT_EN
         chk($sformatf("v%0d_strobe_cnt", i), strobe_cnt, {16'(tbl[i].exp1), 16'(tbl[i].exp0)});
`else
         chk($sformatf("v%0d_strobe_cnt", i), strobe_cnt, 0);
`endif
      end

      // A write at settle count 10 restarts the full settle.
      wr(1'b0, 32'h8000_0000);
      repeat (10) step();
      wr(1'b1, 32'h4000_0000);
      wait_lock(n, bad);
      chk("settle_restart_len", n, 16);
      count_strobes(16, c0, c1);
      chk("settle_restart_c0", c0, 8);
      chk("settle_restart_c1", c1, 4);

      // Asynchronous reset mid-LOCKED, then default increments on both channels.
      waited = 0;
      while (!clken[0] && waited < 10) begin
         step();
         waited++;
      end
      chk("pre_reset_strobe", clken[0], 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_clken", clken, 0);
      chk("async_rst_locked", locked, 0);
      chk("async_rst_strobe_cnt", strobe_cnt, 0);
      @(posedge refclk);
      #1;
      rst_n = 1'b1;
      wait_lock(n, bad);
      chk("rerst_settle_len", n, 16);
      count_strobes(10000, c0, c1);
      chk("default_inc_c0", c0, 5035);
      chk("default_inc_c1", c1, 5035);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
